// File: rtl/swg_frame_sequencer_pkg.sv
// swg: shared types for the sliding-window-generator frame sequencer
// Holds the active/shadow configuration struct, register indices, FSM state
// encoding and the read-back extension helpers.
package swg;

    localparam int INCR_W = 11;
    localparam int CNT_W  = 16;

    localparam logic [3:0] REG_CNT_H       = 4'd0;
    localparam logic [3:0] REG_CNT_W       = 4'd1;
    localparam logic [3:0] REG_CNT_KH      = 4'd2;
    localparam logic [3:0] REG_CNT_KW      = 4'd3;
    localparam logic [3:0] REG_CNT_SIMD    = 4'd4;
    localparam logic [3:0] REG_HEAD_SIMD   = 4'd5;
    localparam logic [3:0] REG_HEAD_KW     = 4'd6;
    localparam logic [3:0] REG_HEAD_KH     = 4'd7;
    localparam logic [3:0] REG_HEAD_W      = 4'd8;
    localparam logic [3:0] REG_HEAD_H      = 4'd9;
    localparam logic [3:0] REG_TAIL_W      = 4'd10;
    localparam logic [3:0] REG_TAIL_H      = 4'd11;
    localparam logic [3:0] REG_TAIL_LAST   = 4'd12;
    localparam logic [3:0] REG_LAST_READ   = 4'd13;
    localparam logic [3:0] REG_LAST_WRITE  = 4'd14;
    localparam logic [3:0] REG_CTRL        = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } swg_state_e;

    typedef struct packed {
        logic        [CNT_W-1:0]  cnt_h;
        logic        [CNT_W-1:0]  cnt_w;
        logic        [CNT_W-1:0]  cnt_kh;
        logic        [CNT_W-1:0]  cnt_kw;
        logic        [CNT_W-1:0]  cnt_simd;
        logic signed [INCR_W-1:0] head_simd;
        logic signed [INCR_W-1:0] head_kw;
        logic signed [INCR_W-1:0] head_kh;
        logic signed [INCR_W-1:0] head_w;
        logic signed [INCR_W-1:0] head_h;
        logic signed [INCR_W-1:0] tail_w;
        logic signed [INCR_W-1:0] tail_h;
        logic signed [INCR_W-1:0] tail_last;
        logic        [CNT_W-1:0]  last_read;
        logic        [CNT_W-1:0]  last_write;
    } swg_cfg_t;

    function automatic logic [31:0] zext_cnt(input logic [CNT_W-1:0] v);
        return 32'(v);
    endfunction

    function automatic logic [31:0] sext_incr(input logic signed [INCR_W-1:0] v);
        return 32'(v);
    endfunction

endpackage

// File: rtl/swg_cfg_regfile.sv
// swg_cfg_regfile: shadow configuration registers and registered read mux
// Ports: ap_clk/ap_rst_n clock and async active-low reset; cfg_we/cfg_addr/
// cfg_wdata register write; ctrl_status CTRL read-back bits from the FSM;
// shadow current shadow configuration; cfg_rdata read data (1-cycle latency).
module swg_cfg_regfile
    import swg::*;
#(
    parameter int INCR_BITWIDTH = INCR_W,
    parameter int CNT_BITWIDTH  = CNT_W
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic [5:0]  ctrl_status,
    output swg_cfg_t    shadow,
    output logic [31:0] cfg_rdata
);

    swg_cfg_t    shadow_q, shadow_d;
    logic [31:0] cfg_rdata_q, cfg_rdata_d;
    logic        unused_wdata;

    assign unused_wdata = ^cfg_wdata[31:CNT_BITWIDTH];

    always_comb begin
        shadow_d = shadow_q;
        if (cfg_we) begin
            case (cfg_addr)
                REG_CNT_H:      shadow_d.cnt_h      = cfg_wdata[CNT_BITWIDTH-1:0];
                REG_CNT_W:      shadow_d.cnt_w      = cfg_wdata[CNT_BITWIDTH-1:0];
                REG_CNT_KH:     shadow_d.cnt_kh     = cfg_wdata[CNT_BITWIDTH-1:0];
                REG_CNT_KW:     shadow_d.cnt_kw     = cfg_wdata[CNT_BITWIDTH-1:0];
                REG_CNT_SIMD:   shadow_d.cnt_simd   = cfg_wdata[CNT_BITWIDTH-1:0];
                REG_HEAD_SIMD:  shadow_d.head_simd  = cfg_wdata[INCR_BITWIDTH-1:0];
                REG_HEAD_KW:    shadow_d.head_kw    = cfg_wdata[INCR_BITWIDTH-1:0];
                REG_HEAD_KH:    shadow_d.head_kh    = cfg_wdata[INCR_BITWIDTH-1:0];
                REG_HEAD_W:     shadow_d.head_w     = cfg_wdata[INCR_BITWIDTH-1:0];
                REG_HEAD_H:     shadow_d.head_h     = cfg_wdata[INCR_BITWIDTH-1:0];
                REG_TAIL_W:     shadow_d.tail_w     = cfg_wdata[INCR_BITWIDTH-1:0];
                REG_TAIL_H:     shadow_d.tail_h     = cfg_wdata[INCR_BITWIDTH-1:0];
                REG_TAIL_LAST:  shadow_d.tail_last  = cfg_wdata[INCR_BITWIDTH-1:0];
                REG_LAST_READ:  shadow_d.last_read  = cfg_wdata[CNT_BITWIDTH-1:0];
                REG_LAST_WRITE: shadow_d.last_write = cfg_wdata[CNT_BITWIDTH-1:0];
                default:        shadow_d = shadow_q;
            endcase
        end
        case (cfg_addr)
            REG_CNT_H:      cfg_rdata_d = zext_cnt(shadow_q.cnt_h);
            REG_CNT_W:      cfg_rdata_d = zext_cnt(shadow_q.cnt_w);
            REG_CNT_KH:     cfg_rdata_d = zext_cnt(shadow_q.cnt_kh);
            REG_CNT_KW:     cfg_rdata_d = zext_cnt(shadow_q.cnt_kw);
            REG_CNT_SIMD:   cfg_rdata_d = zext_cnt(shadow_q.cnt_simd);
            REG_HEAD_SIMD:  cfg_rdata_d = sext_incr(shadow_q.head_simd);
            REG_HEAD_KW:    cfg_rdata_d = sext_incr(shadow_q.head_kw);
            REG_HEAD_KH:    cfg_rdata_d = sext_incr(shadow_q.head_kh);
            REG_HEAD_W:     cfg_rdata_d = sext_incr(shadow_q.head_w);
            REG_HEAD_H:     cfg_rdata_d = sext_incr(shadow_q.head_h);
            REG_TAIL_W:     cfg_rdata_d = sext_incr(shadow_q.tail_w);
            REG_TAIL_H:     cfg_rdata_d = sext_incr(shadow_q.tail_h);
            REG_TAIL_LAST:  cfg_rdata_d = sext_incr(shadow_q.tail_last);
            REG_LAST_READ:  cfg_rdata_d = zext_cnt(shadow_q.last_read);
            REG_LAST_WRITE: cfg_rdata_d = zext_cnt(shadow_q.last_write);
            default:        cfg_rdata_d = {26'b0, ctrl_status};
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            shadow_q    <= '0;
            cfg_rdata_q <= '0;
        end else begin
            shadow_q    <= shadow_d;
            cfg_rdata_q <= cfg_rdata_d;
        end
    end

    assign shadow    = shadow_q;
    assign cfg_rdata = cfg_rdata_q;

endmodule

// File: rtl/swg_frame_sequencer.sv
// swg_frame_sequencer: hands feature-map jobs to the window generator and
// swaps in new configurations only at frame boundaries
// Ports: ap_clk/ap_rst_n clock and async active-low reset; cfg_we/cfg_addr/
// cfg_wdata/cfg_rdata register interface; run_valid/run_ready job handshake;
// fm_done end-of-feature-map pulse; cfg_active configuration in use;
// busy high in ARMED or RUN; frame_cnt completed feature maps.
module swg_frame_sequencer
    import swg::*;
#(
    parameter int INCR_BITWIDTH = INCR_W,
    parameter int CNT_BITWIDTH  = CNT_W
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        run_valid,
    input  logic        run_ready,
    input  logic        fm_done,
    output swg_cfg_t    cfg_active,
    output logic        busy,
    output logic [31:0] frame_cnt
);

    swg_state_e  state_q, state_d;
    swg_cfg_t    cfg_active_q, cfg_active_d, shadow;
    logic        enable_q, enable_d;
    logic        commit_pending_q, commit_pending_d;
    logic        cfg_loaded_q, cfg_loaded_d;
    logic        err_q, err_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic        ctrl_wr, commit_wr, shadow_wr, apply;

    assign ctrl_wr   = cfg_we && (cfg_addr == REG_CTRL);
    assign commit_wr = ctrl_wr && cfg_wdata[0];
    assign shadow_wr = cfg_we && (cfg_addr != REG_CTRL);

    swg_cfg_regfile #(
        .INCR_BITWIDTH(INCR_BITWIDTH),
        .CNT_BITWIDTH (CNT_BITWIDTH)
    ) u_regfile (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .ctrl_status({state_q, err_q, cfg_loaded_q, enable_q, commit_pending_q}),
        .shadow     (shadow),
        .cfg_rdata  (cfg_rdata)
    );

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        apply       = 1'b0;
        enable_d    = ctrl_wr ? cfg_wdata[1] : enable_q;
        err_d       = (fm_done && state_q != ST_RUN) ? 1'b1 :
                      (ctrl_wr && cfg_wdata[3])      ? 1'b0 : err_q;
        case (state_q)
            ST_IDLE: begin
                // A commit arriving this cycle must land before the first job is offered.
                if (commit_pending_q)
                    apply = 1'b1;
                else if (enable_d && cfg_loaded_q && !commit_wr)
                    state_d = ST_ARMED;
            end
            ST_ARMED: begin
                // An offered job completes its handshake even if enable drops the same cycle.
                if (run_ready)
                    state_d = ST_RUN;
                else if (!enable_d)
                    state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (fm_done) begin
                    frame_cnt_d = frame_cnt_q + 32'd1;
                    apply       = commit_pending_q;
                    state_d     = enable_q ? ST_ARMED : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // The copy uses the pre-edge shadow, so same-cycle writes miss this boundary
        // and stay pending for the next one.
        cfg_active_d     = apply ? shadow : cfg_active_q;
        cfg_loaded_d     = cfg_loaded_q | apply;
        commit_pending_d = commit_wr | (commit_pending_q & ~apply) | (apply & shadow_wr);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q          <= ST_IDLE;
            cfg_active_q     <= '0;
            enable_q         <= 1'b0;
            commit_pending_q <= 1'b0;
            cfg_loaded_q     <= 1'b0;
            err_q            <= 1'b0;
            frame_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            cfg_active_q     <= cfg_active_d;
            enable_q         <= enable_d;
            commit_pending_q <= commit_pending_d;
            cfg_loaded_q     <= cfg_loaded_d;
            err_q            <= err_d;
            frame_cnt_q      <= frame_cnt_d;
        end
    end

    assign run_valid  = (state_q == ST_ARMED);
    assign busy       = (state_q != ST_IDLE);
    assign cfg_active = cfg_active_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_swg_frame_sequencer.sv
// tb_swg_frame_sequencer: scenario tasks plus randomized register/commit checks
module tb_swg_frame_sequencer;
    import swg::*;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = 4'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic [31:0] cfg_rdata;
    logic        run_valid;
    logic        run_ready = 1'b0;
    logic        fm_done = 1'b0;
    swg_cfg_t    cfg_active;
    logic        busy;
    logic [31:0] frame_cnt;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] sh [15];
    logic [31:0] act [15];
    logic [31:0] fc = 32'd0;

    swg_frame_sequencer dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .run_valid (run_valid),
        .run_ready (run_ready),
        .fm_done   (fm_done),
        .cfg_active(cfg_active),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Register value as software reads it back: 11-bit increments are signed, counts 16-bit.
    function automatic logic [31:0] exp_rd(input int a, input logic [31:0] d);
        int v;
        if (a >= 5 && a <= 12) begin
            v = int'(d & 32'd2047);
            if (v >= 1024) v = v - 2048;
            return 32'(v);
        end
        return d & 32'h0000_FFFF;
    endfunction

    function automatic logic [31:0] act_val(input int i);
        case (i)
            0:  return 32'(cfg_active.cnt_h);
            1:  return 32'(cfg_active.cnt_w);
            2:  return 32'(cfg_active.cnt_kh);
            3:  return 32'(cfg_active.cnt_kw);
            4:  return 32'(cfg_active.cnt_simd);
            5:  return 32'(cfg_active.head_simd);
            6:  return 32'(cfg_active.head_kw);
            7:  return 32'(cfg_active.head_kh);
            8:  return 32'(cfg_active.head_w);
            9:  return 32'(cfg_active.head_h);
            10: return 32'(cfg_active.tail_w);
            11: return 32'(cfg_active.tail_h);
            12: return 32'(cfg_active.tail_last);
            13: return 32'(cfg_active.last_read);
            default: return 32'(cfg_active.last_write);
        endcase
    endfunction

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cfg_we = 1'b1;
        cfg_addr = 4'(a);
        cfg_wdata = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        cfg_addr = 4'(a);
        step();
        d = cfg_rdata;
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 4 && !run_valid; k++) step();
        n_tests++;
        if (run_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_run_valid: got %b, required 1 within 4 cycles", run_valid);
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        ap_rst_n = 1'b0;
        step();
        step();
        n_tests++;
        if ({run_valid, busy} !== 2'b00 || frame_cnt !== 32'd0 || cfg_rdata !== 32'd0 || cfg_active !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b busy=%b fc=%0d rdata=%h active=%h, required all zero",
                     run_valid, busy, frame_cnt, cfg_rdata, cfg_active);
        end
        ap_rst_n = 1'b1;
        rd(15, r);
        n_tests++;
        if (r !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h, required 0", r);
        end
        for (int i = 0; i < 15; i++) begin
            sh[i] = 32'd0;
            act[i] = 32'd0;
        end
    endtask

    task automatic test_config();
        int vals [15] = '{12, 12, 3, 3, 17, 1, 17, -100, -679, 5, -3, 7, -1, 1000, 2000};
        logic [31:0] r;
        for (int i = 0; i < 15; i++) begin
            wr(i, 32'(vals[i]));
            sh[i] = exp_rd(i, 32'(vals[i]));
        end
        wr(15, 32'h3);
        act = sh;
        for (int k = 0; k < 3 && !run_valid; k++) step();
        n_tests++;
        if (run_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_run_valid: got %b, required 1 within 3 cycles", run_valid);
        end
        for (int i = 0; i < 15; i++) begin
            n_tests++;
            if (act_val(i) !== act[i]) begin
                n_fail++;
                $display("FAIL cfg_active[%0d]: got %h, required %h", i, act_val(i), act[i]);
            end
        end
        rd(8, r);
        n_tests++;
        if (r !== 32'hFFFF_FD59) begin
            n_fail++;
            $display("FAIL readback_head_w: got %h, required FFFFFD59", r);
        end
    endtask

    task automatic test_armed_hold();
        logic [31:0] r;
        run_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            n_tests++;
            if (run_valid !== 1'b1 || act_val(0) !== act[0] || act_val(8) !== act[8]) begin
                n_fail++;
                $display("FAIL armed_hold cycle %0d: got valid=%b h=%h hw=%h, required 1 %h %h",
                         c, run_valid, act_val(0), act_val(8), act[0], act[8]);
            end
        end
        run_ready = 1'b1;
        step();
        run_ready = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || run_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL run_entry: got busy=%b valid=%b, required 1 0", busy, run_valid);
        end
        rd(15, r);
        n_tests++;
        if (r !== 32'h26) begin
            n_fail++;
            $display("FAIL run_ctrl: got %h, required 26", r);
        end
    endtask

    task automatic test_run_commit();
        wr(0, 32'd24);
        sh[0] = 32'd24;
        wr(15, 32'h3);
        n_tests++;
        if (act_val(0) !== act[0]) begin
            n_fail++;
            $display("FAIL run_commit_hold: got H=%0d, required %0d", act_val(0), act[0]);
        end
        fm_done = 1'b1;
        step();
        fm_done = 1'b0;
        act = sh;
        fc++;
        n_tests++;
        if (act_val(0) !== 32'd24 || frame_cnt !== fc) begin
            n_fail++;
            $display("FAIL run_commit_apply: got H=%0d fc=%0d, required 24 %0d", act_val(0), frame_cnt, fc);
        end
    endtask

    task automatic test_back_to_back();
        run_ready = 1'b1;
        step();
        run_ready = 1'b0;
        wr(1, 32'd30);
        sh[1] = 32'd30;
        cfg_we = 1'b1;
        cfg_addr = 4'd15;
        cfg_wdata = 32'h3;
        fm_done = 1'b1;
        step();
        cfg_we = 1'b0;
        fm_done = 1'b0;
        fc++;
        n_tests++;
        if (act_val(1) !== act[1] || frame_cnt !== fc || run_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary_same_cycle: got W=%0d fc=%0d valid=%b, required %0d %0d 1",
                     act_val(1), frame_cnt, run_valid, act[1], fc);
        end
        run_ready = 1'b1;
        step();
        run_ready = 1'b0;
        fm_done = 1'b1;
        step();
        fm_done = 1'b0;
        act = sh;
        fc++;
        n_tests++;
        if (act_val(1) !== 32'd30 || frame_cnt !== fc) begin
            n_fail++;
            $display("FAIL boundary_next: got W=%0d fc=%0d, required 30 %0d", act_val(1), frame_cnt, fc);
        end
    endtask

    task automatic test_err();
        logic [31:0] r;
        wr(15, 32'h0);
        n_tests++;
        if (run_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_armed: got valid=%b busy=%b, required 0 0", run_valid, busy);
        end
        fm_done = 1'b1;
        step();
        fm_done = 1'b0;
        n_tests++;
        if (frame_cnt !== fc) begin
            n_fail++;
            $display("FAIL err_fc: got %0d, required %0d", frame_cnt, fc);
        end
        rd(15, r);
        n_tests++;
        if (r !== 32'h0C) begin
            n_fail++;
            $display("FAIL err_set: got %h, required 0C", r);
        end
        wr(15, 32'h8);
        rd(15, r);
        n_tests++;
        if (r !== 32'h04) begin
            n_fail++;
            $display("FAIL err_clear: got %h, required 04", r);
        end
    endtask

    task automatic test_random();
        int a;
        logic [31:0] d, r;
        for (int it = 0; it < 8; it++) begin
            for (int j = 0; j < 3; j++) begin
                a = int'($urandom_range(14, 0));
                d = $urandom;
                wr(a, d);
                sh[a] = exp_rd(a, d);
            end
            a = int'($urandom_range(14, 0));
            rd(a, r);
            n_tests++;
            if (r !== sh[a]) begin
                n_fail++;
                $display("FAIL rand_readback[%0d] it %0d: got %h, required %h", a, it, r, sh[a]);
            end
            wr(15, 32'h3);
            act = sh;
            wait_valid();
            for (int i = 0; i < 15; i++) begin
                n_tests++;
                if (act_val(i) !== act[i]) begin
                    n_fail++;
                    $display("FAIL rand_active[%0d] it %0d: got %h, required %h", i, it, act_val(i), act[i]);
                end
            end
            run_ready = 1'b1;
            step();
            run_ready = 1'b0;
            a = int'($urandom_range(14, 0));
            d = $urandom;
            wr(a, d);
            sh[a] = exp_rd(a, d);
            repeat ($urandom_range(3, 0)) step();
            fm_done = 1'b1;
            step();
            fm_done = 1'b0;
            fc++;
            n_tests++;
            if (frame_cnt !== fc || act_val(a) !== act[a]) begin
                n_fail++;
                $display("FAIL rand_no_commit it %0d: got fc=%0d f%0d=%h, required %0d %h",
                         it, frame_cnt, a, act_val(a), fc, act[a]);
            end
            wr(15, 32'h0);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] r;
        wr(15, 32'h3);
        wait_valid();
        run_ready = 1'b1;
        step();
        run_ready = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_run_busy: got %b, required 1", busy);
        end
        #2;
        ap_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({run_valid, busy} !== 2'b00 || frame_cnt !== 32'd0 || cfg_rdata !== 32'd0 || cfg_active !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b busy=%b fc=%0d rdata=%h active=%h, required all zero",
                     run_valid, busy, frame_cnt, cfg_rdata, cfg_active);
        end
        step();
        ap_rst_n = 1'b1;
        step();
        rd(15, r);
        n_tests++;
        if (r !== 32'd0 || frame_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset: got ctrl=%h fc=%0d, required 0 0", r, frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_armed_hold();
        test_run_commit();
        test_back_to_back();
        test_err();
        test_random();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
